// File: rtl/peak_stat_pkg.sv
// Shared types and constants for the peak_stat drop-threshold peak detector.
package peak_stat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_SUM_W  = 12;

  // Addend for the per-sample gap counter and the per-event counter.
  localparam int ACC_INC = 1;

endpackage

// File: rtl/peak_stat_if.sv
// Sample/config inputs and published results of peak_stat, bundled as one interface.
interface peak_stat_if #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 8,
  parameter int SUM_W  = 12
);
  logic              sample_vld;
  logic [DATA_W-1:0] data;
  logic              en;
  logic [DATA_W-1:0] thr;
  logic [GAP_W-1:0]  min_gap;
  logic [CNT_W-1:0]  peak_cnt;
  logic [SUM_W-1:0]  interval_sum;
  logic [GAP_W-1:0]  int_min;
  logic [GAP_W-1:0]  int_max;
  logic              sat;
  logic              result_vld;
  logic              busy;

  modport master (
    output sample_vld, data, en, thr, min_gap,
    input  peak_cnt, interval_sum, int_min, int_max, sat, result_vld, busy
  );

  modport slave (
    input  sample_vld, data, en, thr, min_gap,
    output peak_cnt, interval_sum, int_min, int_max, sat, result_vld, busy
  );
endinterface

// File: rtl/peak_stat_sat_acc.sv
// Saturating adder-register: clamps at all-ones and flags any add that would overflow.
module peak_stat_sat_acc #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_add,
  output logic [W-1:0] o_q,
  output logic         o_sat
);
  logic [W-1:0] r_q;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_q} + {1'b0, i_add};
  assign o_sat = i_en && !i_clr && w_sum[W];
  assign o_q   = r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end
endmodule

// File: rtl/peak_stat.sv
// Drop-threshold peak detector with per-window event count and interval sum.
// Optional min/max interval statistics are built when PEAK_STAT_MINMAX_EN is defined.
//
// state | meaning
// IDLE  | accumulators held clear, waiting for en
// TRACK | measuring: samples update peak/gap and count events
// DONE  | one cycle: publish results and pulse result_vld
module peak_stat
  import peak_stat_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int SUM_W  = DEF_SUM_W
) (
  input logic        i_clk,
  input logic        i_rst,
  peak_stat_if.slave bus
);
  state_t            r_state;
  logic [DATA_W-1:0] r_peak;
  logic              r_sat;
  logic [CNT_W-1:0]  r_peak_cnt;
  logic [SUM_W-1:0]  r_interval_sum;
  logic              r_sat_out;
  logic              r_result_vld;
  logic              r_busy;

  logic [GAP_W-1:0]  w_gap;
  logic [CNT_W-1:0]  w_cnt;
  logic [SUM_W-1:0]  w_sum;
  logic              w_idle, w_take, w_below, w_event;
  logic              w_gap_sat, w_cnt_sat, w_sum_sat;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_take  = (r_state == ST_TRACK) && bus.sample_vld && bus.en;
  // Subtraction only matters when data < peak, so it never wraps.
  assign w_below = (bus.data < r_peak);
  assign w_event = w_take && w_below && ((r_peak - bus.data) >= bus.thr) &&
                   (w_gap >= bus.min_gap);

  peak_stat_sat_acc #(.W(GAP_W)) u_gap (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_idle || w_event),
    .i_en(w_take && !w_event), .i_add(GAP_W'(ACC_INC)),
    .o_q(w_gap), .o_sat(w_gap_sat)
  );

  peak_stat_sat_acc #(.W(CNT_W)) u_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_idle),
    .i_en(w_event), .i_add(CNT_W'(ACC_INC)),
    .o_q(w_cnt), .o_sat(w_cnt_sat)
  );

  peak_stat_sat_acc #(.W(SUM_W)) u_sum (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_idle),
    .i_en(w_event), .i_add(SUM_W'(w_gap)),
    .o_q(w_sum), .o_sat(w_sum_sat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_peak         <= '0;
      r_sat          <= 1'b0;
      r_peak_cnt     <= '0;
      r_interval_sum <= '0;
      r_sat_out      <= 1'b0;
      r_result_vld   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_result_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_peak <= '0;
          r_sat  <= 1'b0;
          if (bus.en) begin
            r_state <= ST_TRACK;
            r_busy  <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (!bus.en) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end else if (bus.sample_vld) begin
            if (!w_below) r_peak <= bus.data;
            else if (w_event) r_peak <= '0;
          end
          if (w_gap_sat || w_cnt_sat || w_sum_sat) r_sat <= 1'b1;
        end
        ST_DONE: begin
          r_peak_cnt     <= w_cnt;
          r_interval_sum <= w_sum;
          r_sat_out      <= r_sat;
          r_result_vld   <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PEAK_STAT_MINMAX_EN
  logic [GAP_W-1:0] r_mn, r_mx, r_int_min, r_int_max;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_idle) begin
      r_mn <= '1;
      r_mx <= '0;
    end else if (w_event) begin
      if (w_gap < r_mn) r_mn <= w_gap;
      if (w_gap > r_mx) r_mx <= w_gap;
    end
  end

  // An empty window reports 0 rather than the all-ones seed of mn.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_int_min <= '0;
      r_int_max <= '0;
    end else if (r_state == ST_DONE) begin
      r_int_min <= (w_cnt == '0) ? '0 : r_mn;
      r_int_max <= r_mx;
    end
  end

  assign bus.int_min = r_int_min;
  assign bus.int_max = r_int_max;
`else
  assign bus.int_min = '0;
  assign bus.int_max = '0;
`endif

  assign bus.peak_cnt     = r_peak_cnt;
  assign bus.interval_sum = r_interval_sum;
  assign bus.sat          = r_sat_out;
  assign bus.result_vld   = r_result_vld;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_peak_stat.sv
// Directed bench for peak_stat (CNT_W=4 so counter saturation is reachable quickly).
module tb_peak_stat;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_pulse = 0;
  int   exp_pulse = 0;

  always #5 clk = ~clk;

  peak_stat_if #(.DATA_W(9), .CNT_W(4), .GAP_W(8), .SUM_W(12)) bus ();

  peak_stat #(.DATA_W(9), .CNT_W(4), .GAP_W(8), .SUM_W(12)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always @(posedge clk) if (bus.result_vld === 1'b1) n_pulse++;

  function automatic int mm(input int v);
`ifdef PEAK_STAT_MINMAX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic smp(input int d);
    bus.sample_vld = 1'b1;
    bus.data       = 9'(d);
    @(negedge clk);
    bus.sample_vld = 1'b0;
  endtask

  task automatic win_open(input int t, input int g);
    bus.thr     = 9'(t);
    bus.min_gap = 8'(g);
    bus.en      = 1'b1;
    @(negedge clk);
    chk("busy_open", bus.busy, 1);
    chk("pulse_count", n_pulse, exp_pulse);
    chk("rvld_idle", bus.result_vld, 0);
  endtask

  task automatic win_close();
    bus.en = 1'b0;
    @(negedge clk);
    chk("rvld_early", bus.result_vld, 0);
    @(negedge clk);
    chk("rvld_pulse", bus.result_vld, 1);
    chk("busy_closed", bus.busy, 0);
    exp_pulse++;
  endtask

  task automatic chk_res(input string tag, input int c, input int s, input int mn,
                         input int mx, input int st);
    chk({tag, "_cnt"}, bus.peak_cnt, c);
    chk({tag, "_sum"}, bus.interval_sum, s);
    chk({tag, "_min"}, bus.int_min, mm(mn));
    chk({tag, "_max"}, bus.int_max, mm(mx));
    chk({tag, "_sat"}, bus.sat, st);
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_vld = 1'b0;
    bus.data = '0;
    bus.en = 1'b0;
    bus.thr = '0;
    bus.min_gap = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_res("reset", 0, 0, 0, 0, 0);
    chk("reset_rvld", bus.result_vld, 0);
    chk("reset_busy", bus.busy, 0);

    // rise then drop: event at gap 3
    win_open(16, 0);
    smp(10); smp(20); smp(30); smp(12);
    win_close();
    chk_res("rise_drop", 1, 3, 3, 3, 0);

    // back-to-back: sub-threshold window; previous results must hold meanwhile
    win_open(16, 0);
    smp(30); smp(20); smp(25);
    chk("hold_cnt", bus.peak_cnt, 1);
    chk("hold_sum", bus.interval_sum, 3);
    win_close();
    chk_res("sub_thr", 0, 0, 0, 0, 0);

    // counter saturation with thr=0 (acts as thr=1): 20 events of gap 1
    win_open(0, 0);
    for (int i = 0; i < 20; i++) begin
      smp(2); smp(1);
    end
    win_close();
    chk_res("cnt_sat", 15, 20, 1, 1, 1);

    // refractory gap; also sat must clear for the new window
    win_open(16, 4);
    smp(40); smp(10); smp(40); smp(40); smp(40); smp(5);
    win_close();
    chk_res("refract", 1, 5, 5, 5, 0);

    // en falling with a coincident sample that would be an event: sample dropped
    win_open(16, 0);
    smp(50);
    bus.en = 1'b0;
    bus.sample_vld = 1'b1;
    bus.data = 9'd0;
    @(negedge clk);
    bus.sample_vld = 1'b0;
    @(negedge clk);
    chk("coinc_rvld", bus.result_vld, 1);
    exp_pulse++;
    chk_res("coinc", 0, 0, 0, 0, 0);

    // gap saturation: 300 flat samples, then an event adds the clamped gap
    win_open(1, 0);
    for (int i = 0; i < 300; i++) smp(5);
    smp(0);
    win_close();
    chk_res("gap_sat", 1, 255, 255, 255, 1);

    // reset mid-window: outputs clear, no result pulse
    win_open(16, 0);
    smp(10); smp(20); smp(30); smp(12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    chk_res("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rvld", bus.result_vld, 0);
    repeat (4) @(negedge clk);
    chk("mid_rst_pulses", n_pulse, exp_pulse);
    chk("mid_rst_rvld2", bus.result_vld, 0);

    // fresh window after reset
    win_open(16, 0);
    smp(100); smp(50);
    win_close();
    chk_res("post_rst", 1, 1, 1, 1, 0);
    @(negedge clk);
    chk("final_pulses", n_pulse, exp_pulse);
    chk("final_rvld", bus.result_vld, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/peak_stat.md
# peak_stat

Parametrised drop-threshold peak detector and interval accumulator for the sampled sensor path. It tracks the running maximum of a sample stream and registers an event when a sample falls at least `thr` below that maximum. Per measurement window it counts events and accumulates the sample intervals between them, then publishes the results when `en` drops. It is the successor of the fixed 9-bit / threshold-16 processing stage, adding these features:
- runtime threshold;
- refractory gap;
- explicit sample strobe;
- saturation;
- result-valid pulse;
- optional min/max interval statistics.

## Interface
- `DATA_W`, default 9: sample width.
- `CNT_W`, default 8: event counter width.
- `GAP_W`, default 8: per-interval sample counter width.
- `SUM_W`, default 12: interval accumulator width.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_vld` in 1: one-cycle strobe marking `data` valid (e.g. the 20 Hz tick).
- `data` in DATA_W: unsigned sample.
- `en` in 1: measurement window; high means measure.
- `thr` in DATA_W: drop threshold; sampled on each `sample_vld`.
- `min_gap` in GAP_W: minimum gap before an event is accepted.
- `peak_cnt` out CNT_W: event count of the last completed window.
- `interval_sum` out SUM_W: summed gaps of the last completed window.
- `int_min` out GAP_W: smallest accepted gap (macro-dependent).
- `int_max` out GAP_W: largest accepted gap (macro-dependent).
- `sat` out 1: some accumulator saturated during the last window.
- `result_vld` out 1: one-cycle pulse when the outputs update.
- `busy` out 1: high while in TRACK.

## Operation
- Internal registers:
  - `peak` (DATA_W): running maximum.
  - `gap` (GAP_W): samples since the last event.
  - `cnt` (CNT_W), `sum` (SUM_W): window accumulators.
  - `mn`, `mx` (GAP_W): interval statistics.
  - `sat_r`: saturation flag.
- FSM states: IDLE, TRACK, DONE.
- IDLE:
  - All internal registers are held at zero; `mn` is held at all-ones.
  - `en`=1 moves to TRACK.
- TRACK, on a cycle with `sample_vld`=1 and `en`=1, exactly one of:
  - If `data` >= `peak`: `peak`<=`data`, `gap`<=`gap`+1.
  - Else if (`peak`-`data`) >= `thr` and `gap` >= `min_gap` (event): `cnt`+1, `sum`+=`gap`, `mn`/`mx` updated with `gap`, then `gap`<=0 and `peak`<=0.
  - Else: `gap`<=`gap`+1 and `peak` is unchanged.
- The subtraction `peak`-`data` is evaluated only when `data`<`peak`, so it fits in DATA_W without wrap. `thr`=0 behaves identically to `thr`=1.
- `en`=0 in TRACK moves to DONE. It has priority over a simultaneous `sample_vld`, which is dropped.
- DONE, for one cycle:
  - Copy `cnt`, `sum`, `mn`, `mx`, `sat_r` into the output registers.
  - Pulse `result_vld`.
  - Return to IDLE; IDLE clears the accumulators.
  - Samples arriving in DONE or IDLE are ignored.
- Saturation:
  - `gap`, `cnt` and `sum` saturate at all-ones; they never wrap.
  - Any saturation sets `sat_r`, which is cleared in IDLE.
- If a window closes with no event, the outputs are published as `cnt`=0, `sum`=0, `int_min`=0 and `int_max`=0. `mn` is reported as 0 when `cnt`=0.
- The output registers hold their values until the next DONE.

## Timing
- Reset:
  - Synchronous, at the clock edge with `rst`=1. It wins over every other condition, including mid-window.
  - State returns to IDLE; internal registers clear (`mn` goes to all-ones).
  - `peak_cnt`, `interval_sum`, `int_min`, `int_max`, `sat`, `result_vld` and `busy` are all 0.
- `busy` is registered: it is 1 in the cycle after the edge that enters TRACK.
- Sample latency: a `sample_vld` at edge N updates the internal registers at edge N.
- Result latency:
  - `en`=0 sampled at edge N moves the FSM to DONE.
  - At edge N+1 the outputs update and `result_vld` is high for the cycle after edge N+1.
  - The minimum window turnaround is 3 cycles, from `en` low back to TRACK.
- Back-to-back `sample_vld` on every cycle is legal. The block has full throughput and no stall.

## Configuration
- Macro: `PEAK_STAT_MINMAX_EN`.
- Defined: the `mn`/`mx` registers and compare logic exist; `int_min`/`int_max` report the smallest/largest accepted gap in the window.
- Undefined: the logic is removed; `int_min`/`int_max` are tied to 0. The ports remain, so the interface is unchanged.

## Structure
- Package `peak_stat_pkg`:
  - State enum (IDLE, TRACK, DONE).
  - Default-width localparams.
  - Saturation helper constants.
- One sub-module, `peak_stat_sat_acc`: a parametrised saturating adder-register with width, clear, enable and addend inputs and a sat-flag output. It is instantiated for `gap`, `cnt` and `sum`.

## Test plan
- Rise then drop. Setup: `thr`=16, `min_gap`=0. Samples 10, 20, 30, 12, then `en`=0. Required: `peak_cnt`=1, `interval_sum`=3, `int_min`=`int_max`=3, one `result_vld` pulse.
- Sub-threshold drop. Setup: `thr`=16. Samples 30, 20, 25, then `en`=0. Required: `peak_cnt`=0, `interval_sum`=0.
- Refractory gap. Setup: `thr`=16, `min_gap`=4. Samples 40, 10 give no event (`gap`=1); samples 40, 40, 40, 5 give an event with `gap`=5. Required: `peak_cnt`=1, `interval_sum`=5.
- Saturation. Setup: `CNT_W`=4. Drive 20 events. Required: `peak_cnt`=15, `sat`=1.
- Simultaneous events and reset:
  - `en` falling in the same cycle as `sample_vld`: the sample is ignored.
  - `rst` asserted mid-window: all outputs go to 0 and no `result_vld` pulse occurs.
- Back-to-back windows. Run a second window immediately after the first `result_vld`. Required: the accumulators start from 0 and the first window's outputs hold until the second DONE.
